overlap_split: RTL and testbench

OVERLAP_SPLIT -- requirements
Module: overlap_split

---
 rtl/overlap_split_pkg.sv | 29 ++
 rtl/split_bank_ram.sv | 50 +++++
 rtl/overlap_split.sv | 145 ++++++++++++++
 tb/tb_overlap_split.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlap_split_pkg.sv
// ============================================================================
//  overlap_split_pkg
//  Shared defaults, counter widths and FSM state type for overlap_split.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package overlap_split_pkg;

  localparam int SAMPLE_W_DEF = 64;
  localparam int HOP_DEF      = 18;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WR_CNT_W_DEF = cnt_w(HOP_DEF);
  localparam int RD_CNT_W_DEF = cnt_w(2 * HOP_DEF);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT_OLD = 2'd1,
    EMIT_NEW = 2'd2
  } split_state_e;

endpackage

`default_nettype wire

// File: rtl/split_bank_ram.sv
// ============================================================================
//  split_bank_ram
//  Two banks of DEPTH words, one write port, one async read port, sync clear.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module split_bank_ram #(
  parameter int SAMPLE_W = 64,
  parameter int DEPTH    = 18,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                wr_en,
  input  logic                wr_bank,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_bank,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem_q [2][DEPTH];
  logic [SAMPLE_W-1:0] mem_d [2][DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_bank][wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem_q[b][a] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

`default_nettype wire

// File: rtl/overlap_split.sv
// ============================================================================
//  overlap_split
//  Splits a sample stream into 2*HOP-sample blocks with 50% overlap.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module overlap_split
  import overlap_split_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int HOP      = HOP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_split_pcmSample,
  input  logic                in_split_valid,
  output logic                in_split_ready,
  output logic [SAMPLE_W-1:0] out_split_pcmSample,
  output logic                out_split_valid,
  input  logic                out_split_ready,
  output logic                out_split_last
);

  localparam int WR_W = cnt_w(HOP);
  localparam int RD_W = cnt_w(2 * HOP);
  localparam logic [WR_W-1:0] WR_LAST = WR_W'(HOP - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(2 * HOP - 1);
  localparam logic [RD_W-1:0] RD_HOP  = RD_W'(HOP);

  split_state_e        state_q, state_d;
  logic [WR_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [RD_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                cur_q, cur_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic                wr_en;
  logic [RD_W-1:0]     rd_nxt;
  logic                rd_bank;
  logic [WR_W-1:0]     rd_addr;
  logic [SAMPLE_W-1:0] rd_data;

  assign in_split_ready = reset && (state_q == FILL);
  assign wr_en          = in_split_valid && in_split_ready;

  split_bank_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (HOP),
    .ADDR_W   (WR_W)
  ) u_bank_ram (
    .clk     (clk),
    .clr     (!reset),
    .wr_en   (wr_en),
    .wr_bank (cur_q),
    .wr_addr (wr_cnt_q),
    .wr_data (in_split_pcmSample),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The output register always holds read index rd_cnt_q; the RAM is
  // addressed with the following index so a word is ready on every transfer.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    cur_d       = cur_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_nxt      = rd_cnt_q + RD_W'(1);
    rd_bank     = ~cur_q;
    rd_addr     = '0;

    case (state_q)
      FILL: begin
        if (wr_en) begin
          if (wr_cnt_q == WR_LAST) begin
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            state_d     = EMIT_OLD;
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
          end else begin
            wr_cnt_d = wr_cnt_q + WR_W'(1);
          end
        end
      end
      default: begin
        if (rd_nxt < RD_HOP) begin
          rd_bank = ~cur_q;
          rd_addr = WR_W'(rd_nxt);
        end else begin
          rd_bank = cur_q;
          rd_addr = WR_W'(rd_nxt - RD_HOP);
        end
        if (out_valid_q && out_split_ready) begin
          if (rd_cnt_q == RD_LAST) begin
            state_d     = FILL;
            cur_d       = ~cur_q;
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            rd_cnt_d   = rd_nxt;
            out_data_d = rd_data;
            out_last_d = (rd_nxt == RD_LAST);
            state_d    = (rd_nxt < RD_HOP) ? EMIT_OLD : EMIT_NEW;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      cur_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cur_q       <= cur_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_split_pcmSample = out_data_q;
  assign out_split_valid     = out_valid_q;
  assign out_split_last      = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_overlap_split.sv
// ============================================================================
//  tb_overlap_split
//  Randomised self-checking bench against a hop-queue reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_overlap_split;

  localparam int SW    = 64;
  localparam int HOP   = 18;
  localparam int BOUND = 2000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] in_split_pcmSample = '0;
  logic          in_split_valid = 1'b0;
  logic          in_split_ready;
  logic [SW-1:0] out_split_pcmSample;
  logic          out_split_valid;
  logic          out_split_ready = 1'b0;
  logic          out_split_last;

  overlap_split #(.SAMPLE_W(SW), .HOP(HOP)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_split_pcmSample  (in_split_pcmSample),
    .in_split_valid      (in_split_valid),
    .in_split_ready      (in_split_ready),
    .out_split_pcmSample (out_split_pcmSample),
    .out_split_valid     (out_split_valid),
    .out_split_ready     (out_split_ready),
    .out_split_last      (out_split_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the previous hop, replayed ahead of each new hop.
  logic [SW-1:0] prev_hop[$];
  logic [SW-1:0] exp_data[$];

  logic [SW-1:0] got_data[$];
  bit            got_last[$];
  int            stall_err, rdy_err, early_err, emit_cycles;
  bit            lat_ok, end_ok, timed_out;

  task automatic model_reset();
    prev_hop.delete();
    for (int i = 0; i < HOP; i++) prev_hop.push_back('0);
  endtask

  task automatic model_block(input logic [SW-1:0] samples[$]);
    exp_data = {prev_hop, samples};
    prev_hop = samples;
  endtask

  // Feeds one hop and collects one full output block; observations only.
  task automatic run_block(input logic [SW-1:0] samples[$], input int valid_pct, input int ready_pct);
    int            idx, cyc;
    bit            v, rdy, ov, ol, r, prev_stall, prev_ol;
    logic [SW-1:0] od, prev_od;
    got_data.delete(); got_last.delete();
    stall_err = 0; rdy_err = 0; early_err = 0; emit_cycles = 0;
    lat_ok = 0; end_ok = 0; timed_out = 0;
    out_split_ready = 1'b0;
    idx = 0; cyc = 0;
    while (idx < HOP && cyc < BOUND) begin
      v = ($urandom_range(99) < valid_pct);
      in_split_valid     = v;
      in_split_pcmSample = v ? samples[idx] : {$urandom, $urandom};
      rdy = in_split_ready;
      if (out_split_valid) early_err++;
      @(posedge clk); #1; cyc++;
      if (v && rdy) idx++;
    end
    in_split_valid = 1'b0;
    in_split_pcmSample = '0;
    if (idx < HOP) timed_out = 1;
    lat_ok = out_split_valid;
    prev_stall = 0; prev_od = '0; prev_ol = 0; cyc = 0;
    while (got_data.size() < 2 * HOP && cyc < BOUND) begin
      ov = out_split_valid; od = out_split_pcmSample; ol = out_split_last;
      if (in_split_ready) rdy_err++;
      if (prev_stall && (!ov || od !== prev_od || ol !== prev_ol)) stall_err++;
      r = ($urandom_range(99) < ready_pct);
      out_split_ready = r;
      @(posedge clk); cyc++;
      if (ov && r) begin
        got_data.push_back(od);
        got_last.push_back(ol);
      end
      prev_stall = ov && !r; prev_od = od; prev_ol = ol;
      #1;
    end
    emit_cycles = cyc;
    out_split_ready = 1'b0;
    if (got_data.size() < 2 * HOP) timed_out = 1;
    end_ok = !out_split_valid && in_split_ready;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_split_ready !== 1'b0 || out_split_valid !== 1'b0 || out_split_last !== 1'b0 || out_split_pcmSample !== '0) begin
      bad++;
      $display("FAIL reset_hold: rdy=%b vld=%b last=%b data=%h required 0/0/0/0",
               in_split_ready, out_split_valid, out_split_last, out_split_pcmSample);
    end
    reset = 1'b1;
    #1;
    total++;
    if (in_split_ready !== 1'b1 || out_split_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b vld=%b required 1/0", in_split_ready, out_split_valid);
    end
    model_reset();
  endtask

  task automatic test_first_block();
    logic [SW-1:0] s[$];
    for (int i = 0; i < HOP; i++) s.push_back(SW'(i + 1));
    model_block(s);
    run_block(s, 100, 100);
    total++;
    if (timed_out || early_err != 0 || !lat_ok || !end_ok || emit_cycles != 2 * HOP) begin
      bad++;
      $display("FAIL first_timing: timeout=%b early=%0d lat=%b end=%b cycles=%0d required 0/0/1/1/%0d",
               timed_out, early_err, lat_ok, end_ok, emit_cycles, 2 * HOP);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== (i == 2 * HOP - 1)) begin
        bad++;
        $display("FAIL first_out[%0d]: got %h last=%b required %h last=%b",
                 i, got_data[i], got_last[i], exp_data[i], (i == 2 * HOP - 1));
      end
    end
  endtask

  task automatic test_second_block();
    logic [SW-1:0] s[$];
    for (int i = 0; i < HOP; i++) s.push_back(SW'(i + 19));
    model_block(s);
    run_block(s, 100, 100);
    total++;
    if (timed_out || rdy_err != 0 || !end_ok || emit_cycles != 2 * HOP) begin
      bad++;
      $display("FAIL second_flags: timeout=%b rdy_during_emit=%0d end=%b cycles=%0d required 0/0/1/%0d",
               timed_out, rdy_err, end_ok, emit_cycles, 2 * HOP);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== (i == 2 * HOP - 1)) begin
        bad++;
        $display("FAIL second_out[%0d]: got %h last=%b required %h", i, got_data[i], got_last[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] s[$];
    for (int b = 0; b < 2; b++) begin
      s.delete();
      for (int i = 0; i < HOP; i++) s.push_back({$urandom, $urandom});
      model_block(s);
      run_block(s, 100, 50);
      total++;
      if (timed_out || stall_err != 0 || rdy_err != 0 || !end_ok) begin
        bad++;
        $display("FAIL stall_flags: timeout=%b unstable=%0d rdy_during_emit=%0d end=%b required 0/0/0/1",
                 timed_out, stall_err, rdy_err, end_ok);
      end
      for (int i = 0; i < got_data.size(); i++) begin
        total++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== (i == 2 * HOP - 1)) begin
          bad++;
          $display("FAIL stall_out[%0d]: got %h last=%b required %h", i, got_data[i], got_last[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_input_gaps();
    logic [SW-1:0] s[$];
    for (int b = 0; b < 2; b++) begin
      s.delete();
      for (int i = 0; i < HOP; i++) s.push_back({$urandom, $urandom});
      model_block(s);
      run_block(s, 40, 70);
      total++;
      if (timed_out || early_err != 0 || !lat_ok || stall_err != 0) begin
        bad++;
        $display("FAIL gap_flags: timeout=%b early=%0d lat=%b unstable=%0d required 0/0/1/0",
                 timed_out, early_err, lat_ok, stall_err);
      end
      for (int i = 0; i < got_data.size(); i++) begin
        total++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== (i == 2 * HOP - 1)) begin
          bad++;
          $display("FAIL gap_out[%0d]: got %h last=%b required %h", i, got_data[i], got_last[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [SW-1:0] s[$];
    for (int i = 0; i < HOP; i++) begin
      in_split_valid = 1'b1;
      in_split_pcmSample = SW'(201 + i);
      @(posedge clk); #1;
    end
    in_split_valid = 1'b0;
    out_split_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    out_split_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_split_valid !== 1'b0 || out_split_last !== 1'b0 || out_split_pcmSample !== '0 || in_split_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outs: vld=%b last=%b data=%h rdy=%b required 0/0/0/0",
               out_split_valid, out_split_last, out_split_pcmSample, in_split_ready);
    end
    reset = 1'b1;
    #1;
    total++;
    if (in_split_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_release: rdy=%b required 1", in_split_ready);
    end
    model_reset();
    for (int i = 0; i < HOP; i++) s.push_back(SW'(101 + i));
    model_block(s);
    run_block(s, 100, 100);
    total++;
    if (timed_out || !end_ok) begin
      bad++;
      $display("FAIL midreset_block: timeout=%b end=%b required 0/1", timed_out, end_ok);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== (i == 2 * HOP - 1)) begin
        bad++;
        $display("FAIL midreset_out[%0d]: got %h last=%b required %h", i, got_data[i], got_last[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [SW-1:0] s[$];
    for (int b = 0; b < 3; b++) begin
      s.delete();
      for (int i = 0; i < HOP; i++) s.push_back({$urandom, $urandom});
      model_block(s);
      run_block(s, 60, 50);
      total++;
      if (timed_out || stall_err != 0 || rdy_err != 0 || early_err != 0 || !end_ok) begin
        bad++;
        $display("FAIL random_flags: timeout=%b unstable=%0d rdy=%0d early=%0d end=%b required 0/0/0/0/1",
                 timed_out, stall_err, rdy_err, early_err, end_ok);
      end
      for (int i = 0; i < got_data.size(); i++) begin
        total++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== (i == 2 * HOP - 1)) begin
          bad++;
          $display("FAIL random_out[%0d]: got %h last=%b required %h", i, got_data[i], got_last[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_block();
    test_second_block();
    test_backpressure();
    test_input_gaps();
    test_mid_reset();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
